writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//   Stage directly downstream of the ALU output mux. Captures one ALU result per
//   handshake, steers it by the {store,branch} route code and commits it: GPR
//   write (1 cycle), PC load (1 cycle) or multi-cycle data-RAM store with ack.
//   Holds off the upstream stage while a store is outstanding.
// PARAMETERS
//   DATA_W      32  width of ALU result, GPR data, RAM data, PC value
//   IDX_W       4   GPR destination index width
//   MEM_TIMEOUT 15  max cycles in MEM_WAIT before the store is abandoned
//   RETIRE_W    16  width of the saturating retired-operation counter
// PORTS
//   clk         in   1         rising-edge clock
//   rst         in   1         asynchronous reset, active-high
//   in_valid    in   1         upstream presents a result
//   in_ready    out  1         unit can accept this cycle
//   store       in   1         route code bit 1 (decoder store)
//   branch      in   1         route code bit 0 (decoder branch)
//   alu_bus     in   DATA_W    ALU result
//   dst_idx     in   IDX_W     GPR destination index
//   st_addr     in   DATA_W    RAM address for stores
//   gpr_we      out  1         GPR write strobe (1-cycle pulse)
//   gpr_idx     out  IDX_W     GPR index, valid with gpr_we
//   gpr_wdata   out  DATA_W    GPR data, valid with gpr_we
//   pc_load     out  1         PC load strobe (1-cycle pulse)
//   pc_value    out  DATA_W    branch target, valid with pc_load
//   mem_req     out  1         RAM write request, held until ack/timeout
//   mem_addr    out  DATA_W    RAM address, stable while mem_req
//   mem_wdata   out  DATA_W    RAM data, stable while mem_req
//   mem_ack     in   1         RAM accepted the write
//   err_timeout out  1         1-cycle pulse: store abandoned
//   retired     out  RETIRE_W  committed operations, saturating
// BEHAVIOUR
//   Reset (async, immediate): all outputs 0 except in_ready=1; state IDLE; timer 0.
//   States: IDLE, MEM_WAIT. in_ready = (state==IDLE). Accept = in_valid & in_ready.
//   Route code {store,branch}: 01 PC load; 10 RAM store; 00 and 11 GPR write.
//   IDLE, accept, GPR: next cycle gpr_we=1, gpr_idx/gpr_wdata = captured values;
//     stay IDLE; back-to-back accepts allowed (throughput 1/cycle).
//   IDLE, accept, PC: next cycle pc_load=1, pc_value=alu_bus; stay IDLE.
//   IDLE, accept, store: next cycle mem_req=1, mem_addr=st_addr, mem_wdata=alu_bus;
//     state MEM_WAIT, timer=0. Upstream inputs ignored while in MEM_WAIT.
//   MEM_WAIT: each cycle without ack timer+=1. mem_ack=1 -> mem_req 0 next cycle,
//     retired+=1, IDLE (in_ready=1 next cycle). Ack ignored outside MEM_WAIT.
//   Timeout: ack absent for MEM_TIMEOUT cycles after mem_req rises -> mem_req 0,
//     err_timeout pulse, IDLE, retired unchanged. Ack in the same cycle the timer
//     hits MEM_TIMEOUT: ack wins, no error.
//   gpr_we/pc_load/err_timeout never high >1 cycle per event; at most one of
//     gpr_we, pc_load, mem_req rising per cycle. Data outputs hold last value
//     when strobes low (only mem_* have stability requirement).
//   retired: +1 per GPR write, PC load, acked store; saturates at all-ones.
//   Reset mid-store: mem_req drops asynchronously; no ack pending state kept.
// TESTING
//   rst; in_valid=1 {0,0} alu_bus=0x1234 dst_idx=3 -> next cycle gpr_we=1,
//     gpr_idx=3, gpr_wdata=0x1234; in_ready stays 1; retired=1.
//   {0,1} alu_bus=0x40 then {1,1} alu_bus=7 back-to-back -> pc_load cycle N+1
//     pc_value=0x40, gpr_we cycle N+2 gpr_wdata=7; retired=2.
//   {1,0} alu_bus=0xDEAD st_addr=0x100, ack after 3 cycles -> mem_req high 3
//     cycles addr/data stable, in_ready=0 throughout, 1 the cycle after ack.
//   Store, no ack -> mem_req low and err_timeout pulse after 15 cycles; retired
//     unchanged; ack exactly at cycle 15 -> no err, retired+1.
//   Assert rst while mem_req=1 -> mem_req=0 same cycle, in_ready=1, retired=0.
//   Preload retired=0xFFFE, commit 3 GPR writes -> retired sticks at 0xFFFF.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: captures one ALU result per handshake and commits it
// as a GPR write, a PC load, or a data-RAM store that waits for an ack.
module writeback_unit #(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                store,
    input  logic                branch,
    input  logic [DATA_W-1:0]   alu_bus,
    input  logic [IDX_W-1:0]    dst_idx,
    input  logic [DATA_W-1:0]   st_addr,
    output logic                gpr_we,
    output logic [IDX_W-1:0]    gpr_idx,
    output logic [DATA_W-1:0]   gpr_wdata,
    output logic                pc_load,
    output logic [DATA_W-1:0]   pc_value,
    output logic                mem_req,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    output logic                err_timeout,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic {S_IDLE, S_MEM_WAIT} state_t;

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    // The last cycle of mem_req is the one where the timer reads LIMIT.
    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic                r_gpr_we;
    logic [IDX_W-1:0]    r_gpr_idx;
    logic [DATA_W-1:0]   r_gpr_wdata;
    logic                r_pc_load;
    logic [DATA_W-1:0]   r_pc_value;
    logic                r_mem_req;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_err;
    logic [RETIRE_W-1:0] r_retired;

    logic w_idle;
    logic w_accept;
    logic w_route_pc;
    logic w_route_st;
    logic w_acked;
    logic w_commit;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = in_valid & w_idle;
    assign w_route_pc = ~store & branch;
    assign w_route_st = store & ~branch;
    assign w_acked    = (r_state == S_MEM_WAIT) & mem_ack;
    assign w_commit   = (w_accept & ~w_route_st) | w_acked;

    // Route FSM: issues the commit strobes and tracks the outstanding store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_gpr_we    <= 1'b0;
            r_gpr_idx   <= '0;
            r_gpr_wdata <= '0;
            r_pc_load   <= 1'b0;
            r_pc_value  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_gpr_we  <= 1'b0;
            r_pc_load <= 1'b0;
            r_err     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_route_st) begin
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= st_addr;
                            r_mem_wdata <= alu_bus;
                            r_timer     <= '0;
                            r_state     <= S_MEM_WAIT;
                        end else if (w_route_pc) begin
                            r_pc_load  <= 1'b1;
                            r_pc_value <= alu_bus;
                        end else begin
                            r_gpr_we    <= 1'b1;
                            r_gpr_idx   <= dst_idx;
                            r_gpr_wdata <= alu_bus;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_timer == LIMIT) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of committed operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_commit && !(&r_retired)) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign in_ready    = w_idle;
    assign gpr_we      = r_gpr_we;
    assign gpr_idx     = r_gpr_idx;
    assign gpr_wdata   = r_gpr_wdata;
    assign pc_load     = r_pc_load;
    assign pc_value    = r_pc_value;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_timeout = r_err;
    assign retired     = r_retired;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a
// randomized operation stream checked against a transaction-level model.
module tb_writeback_unit;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TO = 15;
    localparam int RW = 16;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          store = 1'b0;
    logic          branch = 1'b0;
    logic [DW-1:0] alu_bus = '0;
    logic [IW-1:0] dst_idx = '0;
    logic [DW-1:0] st_addr = '0;
    logic          gpr_we;
    logic [IW-1:0] gpr_idx;
    logic [DW-1:0] gpr_wdata;
    logic          pc_load;
    logic [DW-1:0] pc_value;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic          err_timeout;
    logic [RW-1:0] retired;

    int checks = 0;
    int failures = 0;
    int m_ret = 0;
    logic [DW-1:0] m_gpr_d = '0;
    logic [DW-1:0] m_pc = '0;

    writeback_unit #(
        .DATA_W(DW), .IDX_W(IW), .MEM_TIMEOUT(TO), .RETIRE_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .store(store), .branch(branch), .alu_bus(alu_bus),
        .dst_idx(dst_idx), .st_addr(st_addr), .gpr_we(gpr_we),
        .gpr_idx(gpr_idx), .gpr_wdata(gpr_wdata), .pc_load(pc_load),
        .pc_value(pc_value), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err_timeout(err_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v >= RMAX) ? RMAX : v + 1;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || gpr_we !== 1'b0 || pc_load !== 1'b0 ||
            mem_req !== 1'b0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl rdy=%b we=%b pc=%b req=%b err=%b want 1 0 0 0 0",
                     in_ready, gpr_we, pc_load, mem_req, err_timeout);
        end
        checks++;
        if (retired !== '0 || gpr_wdata !== '0 || pc_value !== '0 ||
            mem_addr !== '0 || gpr_idx !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_data retired=%0h wd=%0h pc=%0h ma=%0h want 0",
                     retired, gpr_wdata, pc_value, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ret = 0;
    endtask

    task automatic test_gpr();
        @(negedge clk);
        in_valid = 1'b1; {store, branch} = 2'b00;
        alu_bus = 32'h1234; dst_idx = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        m_ret = sat_inc(m_ret); m_gpr_d = 32'h1234;
        checks++;
        if (gpr_we !== 1'b1 || gpr_idx !== 4'd3 || gpr_wdata !== 32'h1234 ||
            in_ready !== 1'b1 || pc_load !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL gpr_write we=%b idx=%0d d=%0h rdy=%b want 1 3 1234 1",
                     gpr_we, gpr_idx, gpr_wdata, in_ready);
        end
        checks++;
        if (retired !== RW'(m_ret)) begin
            failures++;
            $display("FAIL gpr_retired got=%0d want=%0d", retired, m_ret);
        end
        @(negedge clk);
        checks++;
        if (gpr_we !== 1'b0 || gpr_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL gpr_pulse_hold we=%b d=%0h want 0 1234",
                     gpr_we, gpr_wdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; {store, branch} = 2'b01; alu_bus = 32'h40;
        @(negedge clk);
        m_ret = sat_inc(m_ret); m_pc = 32'h40;
        checks++;
        if (pc_load !== 1'b1 || pc_value !== 32'h40 || gpr_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pc pc=%b val=%0h we=%b want 1 40 0",
                     pc_load, pc_value, gpr_we);
        end
        {store, branch} = 2'b11; alu_bus = 32'd7; dst_idx = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        m_ret = sat_inc(m_ret); m_gpr_d = 32'd7;
        checks++;
        if (gpr_we !== 1'b1 || gpr_wdata !== 32'd7 || gpr_idx !== 4'd5 ||
            pc_load !== 1'b0 || retired !== RW'(m_ret)) begin
            failures++;
            $display("FAIL b2b_gpr we=%b d=%0h idx=%0d pc=%b ret=%0d want 1 7 5 0 %0d",
                     gpr_we, gpr_wdata, gpr_idx, pc_load, retired, m_ret);
        end
    endtask

    // ack_at: cycle of mem_req (1..TO) in which ack is raised; 0 = never.
    task automatic test_store(input logic [DW-1:0] a, input logic [DW-1:0] d,
                              input int ack_at);
        bit done = 0;
        @(negedge clk);
        in_valid = 1'b1; {store, branch} = 2'b10;
        alu_bus = d; st_addr = a;
        @(negedge clk);
        {store, branch} = 2'b00;
        alu_bus = $urandom; dst_idx = IW'($urandom);
        for (int k = 1; k <= TO && !done; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== a || mem_wdata !== d ||
                in_ready !== 1'b0 || gpr_we !== 1'b0 || err_timeout !== 1'b0) begin
                failures++;
                $display("FAIL store_wait c%0d req=%b a=%0h d=%0h rdy=%b we=%b err=%b want 1 %0h %0h 0 0 0",
                         k, mem_req, mem_addr, mem_wdata, in_ready, gpr_we,
                         err_timeout, a, d);
            end
            mem_ack = (k == ack_at);
            @(negedge clk);
            if (k == ack_at) done = 1;
            mem_ack = 1'b0;
        end
        in_valid = 1'b0;
        if (done) m_ret = sat_inc(m_ret);
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 ||
            err_timeout !== !done || retired !== RW'(m_ret) || gpr_we !== 1'b0) begin
            failures++;
            $display("FAIL store_end ack_at=%0d req=%b rdy=%b err=%b ret=%0d want 0 1 %b %0d",
                     ack_at, mem_req, in_ready, err_timeout, retired, !done, m_ret);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || mem_req !== 1'b0 ||
            retired !== RW'(m_ret) || mem_addr !== a) begin
            failures++;
            $display("FAIL store_idle err=%b req=%b ret=%0d ma=%0h want 0 0 %0d %0h",
                     err_timeout, mem_req, retired, mem_addr, m_ret, a);
        end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        in_valid = 1'b1; {store, branch} = 2'b10;
        alu_bus = 32'hCAFE; st_addr = 32'h200;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_ret = 0; m_gpr_d = '0; m_pc = '0;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 || retired !== '0) begin
            failures++;
            $display("FAIL reset_mid_store req=%b rdy=%b ret=%0d want 0 1 0",
                     mem_req, in_ready, retired);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                int at;
                at = $urandom_range(0, TO + 3);
                if (at > TO) at = 0;
                test_store($urandom, $urandom, at);
            end else if (r == 1) begin
                @(negedge clk);
                checks++;
                if (gpr_we !== 1'b0 || pc_load !== 1'b0 ||
                    gpr_wdata !== m_gpr_d || pc_value !== m_pc ||
                    retired !== RW'(m_ret)) begin
                    failures++;
                    $display("FAIL rnd_idle we=%b pc=%b wd=%0h pv=%0h ret=%0d want 0 0 %0h %0h %0d",
                             gpr_we, pc_load, gpr_wdata, m_pc, retired,
                             m_gpr_d, m_pc, m_ret);
                end
            end else begin
                logic [1:0]    rc;
                logic [DW-1:0] v;
                logic [IW-1:0] ix;
                do rc = 2'($urandom); while (rc == 2'b10);
                v = $urandom; ix = IW'($urandom);
                in_valid = 1'b1; {store, branch} = rc;
                alu_bus = v; dst_idx = ix;
                @(negedge clk);
                in_valid = 1'b0;
                m_ret = sat_inc(m_ret);
                if (rc == 2'b01) begin
                    m_pc = v;
                    checks++;
                    if (pc_load !== 1'b1 || pc_value !== v || gpr_we !== 1'b0 ||
                        retired !== RW'(m_ret)) begin
                        failures++;
                        $display("FAIL rnd_pc pc=%b v=%0h we=%b ret=%0d want 1 %0h 0 %0d",
                                 pc_load, pc_value, gpr_we, retired, v, m_ret);
                    end
                end else begin
                    m_gpr_d = v;
                    checks++;
                    if (gpr_we !== 1'b1 || gpr_wdata !== v || gpr_idx !== ix ||
                        pc_load !== 1'b0 || retired !== RW'(m_ret)) begin
                        failures++;
                        $display("FAIL rnd_gpr we=%b d=%0h idx=%0d pc=%b ret=%0d want 1 %0h %0d 0 %0d",
                                 gpr_we, gpr_wdata, gpr_idx, pc_load, retired,
                                 v, ix, m_ret);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        n = (RMAX - 1) - m_ret;
        @(negedge clk);
        in_valid = 1'b1; {store, branch} = 2'b00;
        alu_bus = 32'h55; dst_idx = 4'd1;
        repeat (n) @(negedge clk);
        m_ret = RMAX - 1;
        checks++;
        if (retired !== RW'(m_ret)) begin
            failures++;
            $display("FAIL sat_preload got=%0h want=%0h", retired, m_ret);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            m_ret = sat_inc(m_ret);
            checks++;
            if (gpr_we !== 1'b1 || retired !== RW'(m_ret)) begin
                failures++;
                $display("FAIL sat_step%0d we=%b ret=%0h want 1 %0h",
                         j, gpr_we, retired, m_ret);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (retired !== RW'(RMAX) || gpr_we !== 1'b0) begin
            failures++;
            $display("FAIL sat_final ret=%0h we=%b want ffff 0", retired, gpr_we);
        end
    endtask

    initial begin
        test_reset();
        test_gpr();
        test_back_to_back();
        test_store(32'h100, 32'hDEAD, 3);
        test_store(32'h104, 32'hBEEF, 0);
        test_store(32'h108, 32'hF00D, TO);
        test_store(32'h10C, 32'h0001, 1);
        test_reset_mid_store();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
